// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Device-side emulation of a two-channel 12-bit serial ADC (MCP3202-style
// framing). It serves conversion results taken from parallel channel inputs
// so that an ADC initiator can be exercised without the real chip.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on cs_n/sclk/din (2..3)
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   adc_cs_n/sclk/din  initiator pins (asynchronous to clk)
//   adc_dout        registered serial result
//   ch0_value/ch1_value  12-bit channel values (dial, CdS)
//   busy            frame in progress
//   conv_done       one-clk pulse in the clk D0 first appears on adc_dout
//   conv_word       last served word, loaded with conv_done
//   frame_abort     one-clk pulse when cs_n rises mid-frame
//
// Build option: define ADC_LSBF_EN to add the LSB-first trailer (D1..D11
// after D0 when MSBF=0). Without it the frame always ends after D0.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_din,
  output logic        adc_dout,
  input  logic [11:0] ch0_value,
  input  logic [11:0] ch1_value,
  output logic        busy,
  output logic        conv_done,
  output logic [11:0] conv_word,
  output logic        frame_abort
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CMD, S_NULLB, S_DATA, S_TRAIL, S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sgl_q, sgl_d;
  logic        msbf_q, msbf_d;
  logic [11:0] word_q, word_d;
  logic        dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] conv_word_q, conv_word_d;
  logic        abort_q, abort_d;

  logic        cs_s, sclk_s, din_s, sclk_rise, sclk_fall;
  logic [12:0] diff_01, diff_10;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // 13-bit differences; bit 12 set means the result went negative.
  assign diff_01 = {1'b0, ch0_value} - {1'b0, ch1_value};
  assign diff_10 = {1'b0, ch1_value} - {1'b0, ch0_value};

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], adc_din};
    sclk_prev_d = sclk_s;

    state_d     = state_q;
    cnt_d       = cnt_q;
    sgl_d       = sgl_q;
    msbf_d      = msbf_q;
    word_d      = word_q;
    dout_d      = dout_q;
    conv_word_d = conv_word_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;

    // cs_n high outranks any sclk edge seen in the same clk.
    if (state_q != S_IDLE && cs_s) begin
      state_d = S_IDLE;
      dout_d  = 1'b0;
      abort_d = (state_q == S_CMD) || (state_q == S_NULLB) ||
                (state_q == S_DATA) || (state_q == S_TRAIL);
    end else begin
      case (state_q)
        S_IDLE: begin
          dout_d = 1'b0;
          if (!cs_s) state_d = S_WAIT_START;
        end
        S_WAIT_START: begin
          // leading zeros are ignored; the first 1 is the start bit
          if (sclk_rise && din_s) begin
            state_d = S_CMD;
            cnt_d   = 4'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 4'd1;
            case (cnt_q)
              4'd0: sgl_d = din_s;
              4'd1: begin
                // the word is frozen here for the rest of the frame
                if (sgl_q)      word_d = din_s ? ch1_value : ch0_value;
                else if (din_s) word_d = diff_10[12] ? 12'd0 : diff_10[11:0];
                else            word_d = diff_01[12] ? 12'd0 : diff_01[11:0];
              end
              default: begin
                msbf_d  = din_s;
                state_d = S_NULLB;
              end
            endcase
          end
        end
        S_NULLB: begin
          if (sclk_fall) begin
            dout_d  = 1'b0;
            state_d = S_DATA;
            cnt_d   = 4'd11;
          end
        end
        S_DATA: begin
          if (sclk_fall) begin
            dout_d = word_q[cnt_q];
            if (cnt_q == 4'd0) begin
              done_d      = 1'b1;
              conv_word_d = word_q;
`ifdef ADC_LSBF_EN
              if (!msbf_q) begin
                state_d = S_TRAIL;
                cnt_d   = 4'd1;
              end else begin
                state_d = S_DONE;
              end
`else
              state_d = S_DONE;
`endif
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
`ifdef ADC_LSBF_EN
        S_TRAIL: begin
          // D0 is shared; resend D1..D11 reusing the bit counter
          if (sclk_fall) begin
            dout_d = word_q[cnt_q];
            if (cnt_q == 4'd11) state_d = S_DONE;
            else                cnt_d = cnt_q + 4'd1;
          end
        end
`endif
        S_DONE: begin
          // the last bit is held until the next fall so the initiator can
          // still sample it on the following rise
          if (sclk_fall) dout_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      sgl_q       <= 1'b0;
      msbf_q      <= 1'b0;
      word_q      <= 12'd0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      conv_word_q <= 12'd0;
      abort_q     <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      din_sync_q  <= din_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sgl_q       <= sgl_d;
      msbf_q      <= msbf_d;
      word_q      <= word_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      conv_word_q <= conv_word_d;
      abort_q     <= abort_d;
    end
  end

  assign adc_dout    = dout_q;
  assign busy        = busy_q;
  assign conv_done   = done_q;
  assign conv_word   = conv_word_q;
  assign frame_abort = abort_q;

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable responder for the two-channel 12-bit serial ADC bus (MCP3202-style framing: cs_n, sclk, din, dout). It is the device-side counterpart of the ADC initiator that reads the dial and CdS channels. It serves emulated conversion results from parallel channel inputs, so the game can run on boards without the ADC chip and benches can close the loop on the initiator. It sits between a stimulus source (DIP-derived values or testbench) and the ADC pins of the top level.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on cs_n, sclk and din (2..3).

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- adc_cs_n  input  1  chip select from initiator, active-low
- adc_sclk  input  1  serial clock from initiator, idle low
- adc_din  input  1  command bits from initiator
- adc_dout  output  1  serial result to initiator
- ch0_value  input  12  channel-0 analog value (dial)
- ch1_value  input  12  channel-1 analog value (CdS)
- busy  output  1  high while a frame is in progress (state not IDLE)
- conv_done  output  1  one-clk pulse when the last data bit has been driven
- conv_word  output  12  last word served; updated with conv_done
- frame_abort  output  1  one-clk pulse when cs_n rises mid-frame

## Operation
- cs_n, sclk and din pass through SYNC_STAGES flip-flops. sclk rise/fall are detected on the synchronized signal against a 1-clk delayed copy.
- States: IDLE, WAIT_START, CMD, NULLB, DATA, TRAIL, DONE.
- IDLE: adc_dout=0. Synchronized cs_n low -> WAIT_START.
- WAIT_START: on each sclk rise, sample din. A 0 is a leading zero and is ignored. A 1 is the start bit -> CMD with bit count 0.
- CMD: capture SGL, ODD, MSBF on three consecutive sclk rises. On the rise capturing ODD, latch the selected word:
  - SGL=1: ODD ? ch1_value : ch0_value.
  - SGL=0, ODD=0: ch0 − ch1, floored at 0. SGL=0, ODD=1: ch1 − ch0, floored at 0. Subtraction is done at 13 bits; a negative result gives 12'd0.
- After the MSBF rise -> NULLB. On the next sclk fall, drive the null bit (0) -> DATA.
- DATA: on each of the next 12 sclk falls, drive D11..D0, MSB first. When D0 is driven: pulse conv_done, load conv_word, then go to TRAIL or DONE (see Configuration).
- TRAIL: on 11 sclk falls, drive D1..D11.
- DONE: adc_dout=0. Remain until cs_n high.
- cs_n high seen in any state -> IDLE on the next clk with adc_dout=0.
  - frame_abort pulses if the state was CMD, NULLB, DATA or TRAIL.
  - No abort pulse from WAIT_START or DONE.
- The latched word stays stable for the whole frame; changes on ch0/ch1 after latch affect only the next frame.

## Timing
- Reset values: adc_dout=0, busy=0, conv_done=0, conv_word=12'd0, frame_abort=0, state IDLE, all synchronizers at the idle level (cs_n=1, sclk=0, din=0).
- Pin-to-action latency: SYNC_STAGES+1 clk from a pin edge to the register update (3 clk at default). adc_dout is registered.
- Required input timing: sclk high and low phases each ≥ SYNC_STAGES+3 clk; din stable ≥ SYNC_STAGES+1 clk around each sclk rise.
- conv_done is asserted in the same clk that adc_dout first shows D0.
- If an sclk edge and a cs_n rise are detected in the same clk, the cs_n rise wins: no bit is taken, and the FSM goes to IDLE.
- Reset asserted mid-frame forces all outputs to reset values immediately (asynchronously).

## Configuration
- ADC_LSBF_EN defined: a frame with MSBF=0 goes DATA -> TRAIL and retransmits D1..D11 LSB first, sharing D0. A frame with MSBF=1 goes DATA -> DONE.
- ADC_LSBF_EN undefined: the TRAIL state and its counter are not built. MSBF is captured but ignored, DATA always goes to DONE, and adc_dout stays 0 after D0.

## Test plan
- Single-ended ch0: ch0=12'hA5C, frame 1,1,0,1 at 1 MHz sclk -> null 0 then bits of A5C MSB first; conv_done with conv_word=12'hA5C; no frame_abort.
- Channel select with leading zeros: two leading 0 bits then 1,1,1,1, ch1=12'h3FF -> 3FF returned; leading zeros cause no state change.
- Differential floor: SGL=0, ODD=0 with ch0=100, ch1=300 -> 0. With ODD=1 -> 200 (12'h0C8).
- Abort: cs_n raised after 5 data bits -> frame_abort 1-clk pulse, busy falls, adc_dout=0, no conv_done. The next frame completes normally.
- LSB-first (ADC_LSBF_EN defined), MSBF=0, ch0=12'h801 -> D11..D0 then D1..D11 (0000000000 then 1). Built without the macro: dout=0 after D0.
- Async reset asserted at the 6th data bit -> every output is at its reset value in the same clk; after release, cs_n cycled high then low yields a clean frame.
